// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_subtractor_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle of the serial subtractor; master drives operands, slave returns results.
interface serial_subtractor_ctrl_if
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = A - B - Cin, Br = borrow out.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic D,
    output logic Br
);

    assign D  = A ^ B ^ Cin;
    assign Br = (~A & (B | Cin)) | (B & Cin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell per cycle.
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_subtractor_ctrl_if.slave bus
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_q;
    logic             brw;
    logic             bout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_br;
    logic             last;

    assign last = (cnt == LAST);

    full_subtractor u_cell (
        .A   (a_sr[0]),
        .B   (b_sr[0]),
        .Cin (brw),
        .D   (cell_d),
        .Br  (cell_br)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (last)      state_nx = DONE;
            DONE:                   state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            diff_q  <= '0;
            brw     <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr <= bus.a;
                        b_sr <= bus.b;
                        brw  <= bus.bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
                    brw     <= cell_br;
                    cnt     <= cnt + CW'(1);
                    // On the last bit the shifted-down operands expose their MSBs at bit 0.
                    if (last) begin
                        bout_q <= cell_br;
                        ovf_q  <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
                    end
                end
                DONE:    diff_q <= diff_sr;
                default: ;
            endcase
        end
    end

    // diff_sr is live during DONE; diff_q keeps the result stable while the next operation shifts.
    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
        bus.diff = (state == DONE) ? diff_sr : diff_q;
        bus.bout = bout_q;
        bus.ovf  = ovf_q;
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Randomized and directed checks of serial_subtractor_ctrl against an arithmetic reference model.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;
    localparam int P = W + 2;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        longint ua, ub, sa, sb, r, one;
        one = 1;
        ua  = longint'(av);
        ub  = longint'(bv);
        sa  = av[W-1] ? ua - (one << W) : ua;
        sb  = bv[W-1] ? ub - (one << W) : ub;
        d   = W'(ua - ub - longint'(binv));
        bo  = ua < ub + longint'(binv);
        r   = sa - sb - longint'(binv);
        ov  = (r < -(one << (W-1))) || (r > (one << (W-1)) - 1);
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Drives one start from a negedge, waits (bounded) for done, returns results and leaves DONE.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                         output logic [W-1:0] d, output logic bo, output logic ov, output int lat);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.bin   = binv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 4 * W) begin
            @(negedge clk);
            lat++;
        end
        d  = bus.diff;
        bo = bus.bout;
        ov = bus.ovf;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(negedge clk);
        vectors += 5;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        if (bus.diff !== '0)   begin miscompares++; $display("FAIL reset_diff got=%h exp=00", bus.diff); end
        if (bus.bout !== 1'b0) begin miscompares++; $display("FAIL reset_bout got=%b exp=0", bus.bout); end
        if (bus.ovf !== 1'b0)  begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[6]  = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F, 8'h10};
        logic [W-1:0] tb_[6] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF, 8'h01};
        logic         tc[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] ed[6]  = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80, 8'h0F};
        logic         eb[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic         eo[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] d;
        logic         bo, ov;
        int           lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb_[i], tc[i], d, bo, ov, lat);
            vectors += 5;
            if (lat !== W + 1) begin miscompares++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, W + 1); end
            if (d !== ed[i])   begin miscompares++; $display("FAIL dir%0d_diff got=%h exp=%h", i, d, ed[i]); end
            if (bo !== eb[i])  begin miscompares++; $display("FAIL dir%0d_bout got=%b exp=%b", i, bo, eb[i]); end
            if (ov !== eo[i])  begin miscompares++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ov, eo[i]); end
            if (bus.diff !== ed[i]) begin miscompares++; $display("FAIL dir%0d_hold got=%h exp=%h", i, bus.diff, ed[i]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av, bv, d, md;
        logic         cv, bo, ov, mb, mo;
        int           lat;
        for (int i = 0; i < 400; i++) begin
            av = pick();
            bv = pick();
            cv = 1'($urandom);
            model(av, bv, cv, md, mb, mo);
            do_op(av, bv, cv, d, bo, ov, lat);
            vectors += 4;
            if (lat !== W + 1) begin miscompares++; $display("FAIL rnd_latency a=%h b=%h got=%0d exp=%0d", av, bv, lat, W + 1); end
            if (d !== md) begin miscompares++; $display("FAIL rnd_diff a=%h b=%h bin=%b got=%h exp=%h", av, bv, cv, d, md); end
            if (bo !== mb) begin miscompares++; $display("FAIL rnd_bout a=%h b=%h bin=%b got=%b exp=%b", av, bv, cv, bo, mb); end
            if (ov !== mo) begin miscompares++; $display("FAIL rnd_ovf a=%h b=%h bin=%b got=%b exp=%b", av, bv, cv, ov, mo); end
        end
    endtask

    task automatic test_ignore_start();
        logic exp_busy, exp_done;
        bus.start = 1'b1;
        bus.a     = 8'h33;
        bus.b     = 8'h11;
        bus.bin   = 1'b0;
        @(negedge clk);
        for (int cyc = 1; cyc <= W + 4; cyc++) begin
            exp_busy = (cyc <= W + 1);
            exp_done = (cyc == W + 1);
            vectors += 2;
            if (bus.busy !== exp_busy) begin miscompares++; $display("FAIL ign_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy); end
            if (bus.done !== exp_done) begin miscompares++; $display("FAIL ign_done cyc=%0d got=%b exp=%b", cyc, bus.done, exp_done); end
            if (exp_done) begin
                vectors += 3;
                if (bus.diff !== 8'h22) begin miscompares++; $display("FAIL ign_diff got=%h exp=22", bus.diff); end
                if (bus.bout !== 1'b0)  begin miscompares++; $display("FAIL ign_bout got=%b exp=0", bus.bout); end
                if (bus.ovf !== 1'b0)   begin miscompares++; $display("FAIL ign_ovf got=%b exp=0", bus.ovf); end
            end
            bus.start = (cyc == 1 || cyc == 3 || cyc == 5);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.bin   = 1'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_rst_abort();
        logic [W-1:0] d;
        logic         bo, ov;
        int           lat;
        do_op(8'h0F, 8'hF0, 1'b1, d, bo, ov, lat);
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h22;
        bus.bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors += 5;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        if (bus.diff !== '0)   begin miscompares++; $display("FAIL abort_diff got=%h exp=00", bus.diff); end
        if (bus.bout !== 1'b0) begin miscompares++; $display("FAIL abort_bout got=%b exp=0", bus.bout); end
        if (bus.ovf !== 1'b0)  begin miscompares++; $display("FAIL abort_ovf got=%b exp=0", bus.ovf); end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 2 * W; cyc++) begin
            @(negedge clk);
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet cyc=%0d got done=%b busy=%b exp done=0 busy=0", cyc, bus.done, bus.busy);
            end
        end
        do_op(8'h10, 8'h01, 1'b0, d, bo, ov, lat);
        vectors += 2;
        if (lat !== W + 1) begin miscompares++; $display("FAIL abort_restart_latency got=%0d exp=%0d", lat, W + 1); end
        if (d !== 8'h0F)   begin miscompares++; $display("FAIL abort_restart_diff got=%h exp=0f", d); end
    endtask

    task automatic test_back_to_back();
        localparam int NOPS = 500;
        logic [W-1:0] qa[$], qb[$];
        logic         qc[$];
        logic [W-1:0] av, bv, md;
        logic         cv, mb, mo, exp_done;
        bus.start = 1'b1;
        av = pick(); bv = pick(); cv = 1'($urandom);
        bus.a = av; bus.b = bv; bus.bin = cv;
        qa.push_back(av); qb.push_back(bv); qc.push_back(cv);
        for (int c = 1; c < NOPS * P; c++) begin
            @(negedge clk);
            exp_done = (c % P == W + 1);
            vectors++;
            if (bus.done !== exp_done) begin miscompares++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", c, bus.done, exp_done); end
            if (exp_done && qa.size() > 0) begin
                model(qa.pop_front(), qb.pop_front(), qc.pop_front(), md, mb, mo);
                vectors += 3;
                if (bus.diff !== md) begin miscompares++; $display("FAIL b2b_diff cyc=%0d got=%h exp=%h", c, bus.diff, md); end
                if (bus.bout !== mb) begin miscompares++; $display("FAIL b2b_bout cyc=%0d got=%b exp=%b", c, bus.bout, mb); end
                if (bus.ovf !== mo)  begin miscompares++; $display("FAIL b2b_ovf cyc=%0d got=%b exp=%b", c, bus.ovf, mo); end
            end
            av = pick(); bv = pick(); cv = 1'($urandom);
            bus.a = av; bus.b = bv; bus.bin = cv;
            if (c % P == 0) begin
                qa.push_back(av); qb.push_back(bv); qc.push_back(cv);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (qa.size() != 0) begin miscompares++; $display("FAIL b2b_pending got=%0d exp=0", qa.size()); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_rst_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
